// File: rtl/demux_lane_scheduler.sv
// rtl/demux_lane_scheduler.sv - round-robin scheduler for a 2-bit 1-to-4 lane demux
// Words wait on the target lane's ready; a stalled lane is skipped after STALL_MAX cycles.
module demux_lane_scheduler #(
   parameter int STALL_MAX = 7,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       en,
   input  logic             in_valid,
   input  logic [1:0]       in_data,
   output logic             in_ready,
   input  logic [3:0]       lane_rdy,
   output logic [1:0]       sel,
   output logic [7:0]       z,
   output logic [3:0]       lane_vld,
   output logic [CNT_W-1:0] skip_cnt
);

   typedef enum logic {IDLE, DELIVER} state_t;

   localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

   state_t           state, state_n;
   logic [1:0]       data_q, data_n;
   logic [1:0]       tgt, tgt_n;
   logic [1:0]       ptr, ptr_n;
   logic [7:0]       stall_cnt, stall_n;
   logic [CNT_W-1:0] skip_n;
   logic [1:0]       sel_n;
   logic [7:0]       z_n;
   logic [3:0]       vld_n;
   logic [2:0]       pick;
   logic             accept, complete;

   // {found, lane}: first enabled lane among start .. start+span-1 (mod 4)
   function automatic logic [2:0] find_lane(input logic [1:0] start, input logic [3:0] mask,
                                            input int span);
      logic [2:0] r;
      logic [1:0] l;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         l = start + 2'(i);
         if (i < span && mask[l]) r = {1'b1, l};
      end
      return r;
   endfunction

   assign in_ready = rst_n && (en != 4'b0000) && (state == IDLE || lane_rdy[tgt]);
   assign accept   = in_valid && in_ready;
   assign complete = (state == DELIVER) && lane_rdy[tgt];

   always_comb begin
      state_n = state;
      data_n  = data_q;
      tgt_n   = tgt;
      ptr_n   = ptr;
      stall_n = stall_cnt;
      skip_n  = skip_cnt;
      pick    = 3'b000;

      if (complete) begin
         ptr_n   = tgt + 2'd1;
         stall_n = 8'd0;
         state_n = IDLE;
      end

      if (accept) begin
         // ptr_n already points past a just-completed lane, giving one word per cycle
         pick    = find_lane(ptr_n, en, 4);
         tgt_n   = pick[1:0];
         data_n  = in_data;
         stall_n = 8'd0;
         state_n = DELIVER;
      end else if (state == DELIVER && !lane_rdy[tgt]) begin
         if (stall_cnt == STALL_LAST) begin
            stall_n = 8'd0;
            pick    = find_lane(tgt + 2'd1, en, 3);
            if (pick[2]) begin
               tgt_n = pick[1:0];
               if (skip_cnt != {CNT_W{1'b1}}) skip_n = skip_cnt + 1'b1;
            end
         end else begin
            stall_n = stall_cnt + 8'd1;
         end
      end

      if (state_n == DELIVER) begin
         sel_n = tgt_n;
         z_n   = 8'(data_n) << {tgt_n, 1'b0};
         vld_n = 4'b0001 << tgt_n;
      end else begin
         sel_n = sel;
         z_n   = 8'h00;
         vld_n = 4'b0000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         data_q    <= 2'b00;
         tgt       <= 2'b00;
         ptr       <= 2'b00;
         stall_cnt <= 8'd0;
         skip_cnt  <= '0;
         sel       <= 2'b00;
         z         <= 8'h00;
         lane_vld  <= 4'b0000;
      end else begin
         state     <= state_n;
         data_q    <= data_n;
         tgt       <= tgt_n;
         ptr       <= ptr_n;
         stall_cnt <= stall_n;
         skip_cnt  <= skip_n;
         sel       <= sel_n;
         z         <= z_n;
         lane_vld  <= vld_n;
      end
   end

endmodule
